pc_select_freg: RTL



---
 rtl/pc_select_freg.sv | 101 ++++++++++
 1 files changed

// File: rtl/pc_select_freg.sv
// Fetch-side PC selection and F pipeline register for the pipelined Y86-64 core.
// A run/halt/error state machine freezes the front end after a non-AOK write-back status.
module pc_select_freg #(
  parameter logic [63:0] RESET_PC = 64'd64,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             F_stall,
  input  logic [3:0]       f_icode,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [63:0]      M_valA,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  input  logic [1:0]       W_stat,
  output logic [63:0]      f_pc,
  output logic [63:0]      F_predPC,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [3:0] I_JXX  = 4'd7;
  localparam logic [3:0] I_CALL = 4'd8;
  localparam logic [3:0] I_RET  = 4'd9;

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [63:0]     pred;
  logic            mispredict;
  logic            load;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_nxt = state;
    if (state == S_RUN) begin
      if (W_stat == ST_HLT)      state_nxt = S_HALT;
      else if (W_stat != ST_AOK) state_nxt = S_ERR;
    end
  end

  always_comb begin
    pred = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) pred = f_valC;
  end

  assign mispredict = (M_icode == I_JXX) && !M_cnd;

  always_comb begin
    f_pc   = F_predPC;
    pc_src = 2'd0;
    if (state != S_RUN) begin
      pc_src = 2'd3;
    end else if (mispredict) begin
      f_pc   = M_valA;
      pc_src = 2'd1;
    end else if (W_icode == I_RET) begin
      f_pc   = W_valM;
      pc_src = 2'd2;
    end
  end

  // A non-AOK status blocks the load in the same cycle it is seen.
  assign load = (state == S_RUN) && !F_stall && (W_stat == ST_AOK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      halted      <= 1'b0;
      error       <= 1'b0;
      F_predPC    <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == S_HALT);
      error  <= (state_nxt == S_ERR);
      if (load) begin
        F_predPC    <= pred;
        fetch_count <= sat_inc(fetch_count);
      end
    end
  end

endmodule
